// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bram_pkg
//  Purpose  : Shared geometry of the 8 x 4-bit circular BRAM (also used by
//             the LFSR writer side) and the drain FSM state encoding.
//  Contents : DATA_W, DEPTH, ADDR_W, state_t
//  Revision : 1.0  initial release
// ============================================================================
package bram_pkg;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    // CSUM is only reached when READOUT_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        CSUM  = 3'd4
    } state_t;

endpackage : bram_pkg
`default_nettype wire

// File: rtl/bram_reader_if.sv
`default_nettype none
// ============================================================================
//  Module   : bram_reader_if
//  Purpose  : Bundles the reader's control, BRAM read port and output stream.
//  Modports : master - the reader (drives rd_*, out_*, busy, done)
//             slave  - the environment (drives start, wr_ptr, fill_cnt,
//                      rd_data, out_ready)
//  Revision : 1.0  initial release
// ============================================================================
interface bram_reader_if;
    import bram_pkg::*;

    logic                start;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     fill_cnt;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [DATA_W-1:0]   rd_data;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;
    logic                busy;
    logic                done;

    modport master (
        input  start, wr_ptr, fill_cnt, rd_data, out_ready,
        output rd_en, rd_addr, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        output start, wr_ptr, fill_cnt, rd_data, out_ready,
        input  rd_en, rd_addr, out_valid, out_data, out_last, busy, done
    );

endinterface : bram_reader_if
`default_nettype wire

// File: rtl/bram_reader.sv
`default_nettype none
// ============================================================================
//  Module   : bram_reader
//  Purpose  : On start, snapshots the writer's pointer and fill count and
//             drains the circular BRAM oldest-to-newest through its
//             synchronous read port onto a valid/ready stream with last flag.
//  Ports    : clk   - read clock, posedge
//             reset - asynchronous, active-high
//             bus   - bram_reader_if.master (start/wr_ptr/fill_cnt in,
//                     rd_en/rd_addr/rd_data BRAM port, out_* stream,
//                     busy/done status)
//  Options  : READOUT_CHECKSUM_EN - append an XOR checksum beat to each drain
//  Revision : 1.0  initial release
// ============================================================================
module bram_reader
    import bram_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      reset,
    bram_reader_if.master  bus
);

    state_t              state_q,     state_d;
    logic [ADDR_W-1:0]   ptr_q,       ptr_d;
    logic [ADDR_W:0]     rem_q,       rem_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic                out_last_q,  out_last_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
`ifdef READOUT_CHECKSUM_EN
    logic [DATA_W-1:0]   acc_q,       acc_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef READOUT_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef READOUT_CHECKSUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef READOUT_CHECKSUM_EN
        acc_d       = acc_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef READOUT_CHECKSUM_EN
                    acc_d = '0;
`endif
                    if (bus.fill_cnt != '0) begin
                        // Low-bit subtraction: a full buffer (fill_cnt=DEPTH)
                        // lands on wr_ptr, which is the oldest entry.
                        ptr_d   = bus.wr_ptr - bus.fill_cnt[ADDR_W-1:0];
                        rem_d   = bus.fill_cnt;
                        busy_d  = 1'b1;
                        state_d = ISSUE;
                    end else begin
`ifdef READOUT_CHECKSUM_EN
                        // Empty drain still emits a zero checksum beat.
                        out_data_d  = '0;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        state_d     = CSUM;
`else
                        done_d = 1'b1;
`endif
                    end
                end
            end

            ISSUE: begin
                state_d = WAIT;
            end

            WAIT: begin
                out_data_d  = bus.rd_data;
                out_valid_d = 1'b1;
`ifdef READOUT_CHECKSUM_EN
                out_last_d  = 1'b0;
`else
                out_last_d  = (rem_q == (ADDR_W+1)'(1));
`endif
                state_d     = HOLD;
            end

            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    rem_d       = rem_q - (ADDR_W+1)'(1);
`ifdef READOUT_CHECKSUM_EN
                    acc_d       = acc_q ^ out_data_q;
`endif
                    if (rem_q == (ADDR_W+1)'(1)) begin
`ifdef READOUT_CHECKSUM_EN
                        out_data_d  = acc_q ^ out_data_q;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = CSUM;
`else
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
`endif
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

`ifdef READOUT_CHECKSUM_EN
            CSUM: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read strobe is decoded from state so it can only ever appear in ISSUE.
    assign bus.rd_en     = (state_q == ISSUE);
    assign bus.rd_addr   = (state_q == ISSUE) ? ptr_q : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule : bram_reader
`default_nettype wire

// File: doc/bram_reader.md
Name: bram_reader

Overview:
- Read-side drain engine for the 8-entry x 4-bit circular BRAM filled by the LFSR writer.
- On a start pulse it snapshots the writer's pointer and fill count, then reads entries from oldest to newest through the BRAM's synchronous read port.
- Each entry is presented on a valid/ready output stream with a last flag.
- Single clock domain (the 125 MHz read clock).

Parameters:
- DATA_W, 4, width of one BRAM entry
- DEPTH, 8, number of BRAM entries (power of two)
- ADDR_W, 3, log2(DEPTH)

Ports:
- clk  in  1  read-side clock; all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  single-cycle request to drain the buffer
- wr_ptr  in  ADDR_W  address the writer will write next
- fill_cnt  in  ADDR_W+1  valid entries in the BRAM, 0..DEPTH
- rd_en  out  1  BRAM read strobe
- rd_addr  out  ADDR_W  BRAM read address
- rd_data  in  DATA_W  BRAM read data, valid the cycle after rd_en
- out_valid  out  1  out_data holds a beat
- out_ready  in  1  consumer accepts a beat
- out_data  out  DATA_W  drained entry
- out_last  out  1  final beat of this drain
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse when a drain completes

Behaviour:
- Reset values: rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, state=IDLE. Reset asserted mid-drain aborts the drain immediately and produces no done pulse.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE, start=1, fill_cnt>0:
  - ptr <= (wr_ptr - fill_cnt) mod DEPTH; the subtraction uses the low ADDR_W bits, so fill_cnt=DEPTH gives ptr=wr_ptr.
  - remaining <= fill_cnt; busy <= 1; go to ISSUE.
- IDLE, start=1, fill_cnt=0: done pulses the next cycle; no beats are produced; stay in IDLE.
- start is ignored while busy=1.
- ISSUE: rd_en=1 and rd_addr=ptr for exactly one cycle; go to WAIT.
- WAIT: out_data <= rd_data; out_valid <= 1; out_last <= (remaining==1); go to HOLD.
- HOLD:
  - out_data, out_last and out_valid stay stable until out_ready=1.
  - On the handshake: out_valid <= 0; ptr <= ptr+1 (wraps DEPTH-1 to 0); remaining <= remaining-1.
  - If remaining was 1: busy <= 0, done pulses, go to IDLE. Otherwise go to ISSUE.
- Timing:
  - Latency from start to first out_valid is 3 cycles.
  - Peak throughput is 1 beat per 3 cycles.
  - No new rd_en is issued while a beat is unaccepted.
- Coherence: the BRAM is read live. An entry overwritten by the writer during a drain is returned with its new value. fill_cnt and wr_ptr are sampled only at start.
- At most one read is in flight; rd_en is never asserted outside ISSUE.

Optional Feature:
- Macro: READOUT_CHECKSUM_EN.
- When defined:
  - Add a CSUM state and a DATA_W accumulator, cleared at start and XORed with every accepted data beat.
  - After the last data beat is accepted, present one extra beat: out_data = accumulator, out_last = 1.
  - out_last is 0 on all data beats.
  - done pulses when the checksum beat is accepted.
  - For fill_cnt=0, a single checksum beat of 0 is emitted.
- When undefined: no accumulator and no CSUM state; behaviour is exactly as above.

Decomposition:
- Package bram_pkg:
  - DATA_W, DEPTH and ADDR_W defaults, shared with the writer interface.
  - FSM state encoding constants: IDLE, ISSUE, WAIT, HOLD, CSUM.
- Single module; no sub-module is warranted. Pointer wrap and remaining count are inline registers.

Test Plan:
- Full buffer, BRAM = {0:1, 1:2, …, 7:8}, wr_ptr=3, fill_cnt=8, out_ready=1, start -> rd_addr sequence 3,4,5,6,7,0,1,2; out_data 4,5,6,7,8,1,2,3; out_last only on data 3; one done pulse.
- Partial buffer: wr_ptr=5, fill_cnt=3 -> rd_addr 2,3,4; exactly 3 beats; out_last on the third beat.
- Empty buffer: fill_cnt=0, start -> done pulses 1 cycle later; out_valid and rd_en stay 0. With the macro: one beat of 0000 with out_last=1.
- Backpressure: hold out_ready=0 for 5 cycles on beat 2 -> out_data and out_valid stable; no rd_en during the stall; sequence resumes intact. A start pulse during the stall is ignored.
- Reset mid-drain: assert reset after beat 3 of 8 -> out_valid, busy and rd_en drop immediately with no done pulse. A following start with fill_cnt=8 drains from the newly computed oldest entry.
- With READOUT_CHECKSUM_EN: entries 0001, 0010, 0100 -> fourth beat out_data=0111 with out_last=1; done follows its acceptance.
